// File: rtl/tmds_channel_rx_pkg.sv
// tmds_channel_rx_pkg: TMDS character constants, alignment state type and encode/decode helpers
package tmds_channel_rx_pkg;
  localparam int TMDS_BITS = 10;
  typedef logic [TMDS_BITS-1:0] tmds_t;
  typedef enum logic {SEARCH, LOCKED} tmds_align_state_t;
  localparam tmds_t C0 = 10'b1101010100;
  localparam tmds_t C1 = 10'b0010101011;
  localparam tmds_t C2 = 10'b0101010100;
  localparam tmds_t C3 = 10'b1010101011;
  function automatic logic is_control_token(tmds_t w);
    return w == C0 || w == C1 || w == C2 || w == C3;
  endfunction
  function automatic logic tmds_qm8(logic [7:0] d);
    return !($countones(d) > 4 || ($countones(d) == 4 && !d[0]));
  endfunction
  function automatic tmds_t tmds_encode(logic [7:0] d, logic de, logic [1:0] c, int disparity);
    logic [8:0] qm;
    int n1;
    if (!de) return c == 2'b00 ? C0 : c == 2'b01 ? C1 : c == 2'b10 ? C2 : C3;
    qm[8] = tmds_qm8(d);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = qm[8] ? qm[i-1] ^ d[i] : ~(qm[i-1] ^ d[i]);
    n1 = $countones(qm[7:0]);
    if (disparity == 0 || n1 == 4) return {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
    if ((disparity > 0 && n1 > 4) || (disparity < 0 && n1 < 4)) return {1'b1, qm[8], ~qm[7:0]};
    return {1'b0, qm[8], qm[7:0]};
  endfunction
  function automatic logic [7:0] tmds_decode(tmds_t q, logic data_active);
    logic [7:0] d;
    logic [7:0] o;
    if (!data_active) return {6'b0, q == C2 || q == C3, q == C1 || q == C3};
    d = q[9] ? ~q[7:0] : q[7:0];
    o[0] = d[0];
    for (int i = 1; i < 8; i++) o[i] = q[8] ? d[i] ^ d[i-1] : ~(d[i] ^ d[i-1]);
    return o;
  endfunction
endpackage

// File: rtl/tmds_channel_rx_aligner.sv
// tmds_word_aligner: selects the 10-bit character at offset from {raw_in, raw_prev} and registers it with its control flag
module tmds_word_aligner
  import tmds_channel_rx_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] raw_in,
  input  logic [3:0] offset,
  output logic [9:0] word,
  output logic       is_ctrl
);
  logic [9:0] raw_prev;
  logic [9:0] a;
  assign a = 10'({raw_in, raw_prev} >> offset);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      raw_prev <= '0;
      word <= '0;
      is_ctrl <= 1'b0;
    end else begin
      raw_prev <= raw_in;
      word <= a;
      is_ctrl <= is_control_token(a);
    end
endmodule

// File: rtl/tmds_channel_rx.sv
// tmds_channel_rx: one TMDS channel receiver -- control-token boundary search, lock tracking and character decode
module tmds_channel_rx
  import tmds_channel_rx_pkg::*;
#(
  parameter int LOCK_COUNT   = 16,
  parameter int DWELL_CYCLES = 4400,
  parameter int LOSS_TIMEOUT = 4400
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] raw_in,
  output logic [7:0] data_out,
  output logic       de_out,
  output logic [1:0] ctrl_out,
  output logic       locked,
  output logic [3:0] offset,
  output logic       decode_err
);
  localparam int RW = $clog2(LOCK_COUNT + 1);
  localparam int DW = $clog2(DWELL_CYCLES + 1);
  localparam int GW = $clog2(LOSS_TIMEOUT + 1);
  tmds_align_state_t state;
  logic [9:0] s1_word;
  logic s1_ctrl;
  logic [RW-1:0] run_cnt;
  logic [DW-1:0] dwell_cnt;
  logic [GW-1:0] gap_cnt;
  logic skip;
  logic lock_now, dwell_done, loss_now, lock_nxt, err;
  logic [3:0] offset_inc;
  logic [7:0] dec;
  tmds_word_aligner u_align (
    .clk(clk),
    .rst_n(rst_n),
    .raw_in(raw_in),
    .offset(offset),
    .word(s1_word),
    .is_ctrl(s1_ctrl)
  );
  assign lock_now = state == SEARCH && !skip && s1_ctrl && run_cnt == RW'(LOCK_COUNT - 1);
  assign dwell_done = state == SEARCH && dwell_cnt == DW'(DWELL_CYCLES - 1);
  assign loss_now = state == LOCKED && !s1_ctrl && gap_cnt == GW'(LOSS_TIMEOUT - 1);
  assign lock_nxt = lock_now || (state == LOCKED && !loss_now);
  assign offset_inc = offset == 4'd9 ? 4'd0 : offset + 4'd1;
  assign dec = tmds_decode(s1_word, !s1_ctrl);
  assign err = !s1_ctrl && tmds_qm8(dec) != s1_word[8];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= SEARCH;
      offset <= '0;
      run_cnt <= '0;
      dwell_cnt <= '0;
      gap_cnt <= '0;
      skip <= 1'b0;
      locked <= 1'b0;
      data_out <= '0;
      de_out <= 1'b0;
      ctrl_out <= '0;
      decode_err <= 1'b0;
    end else begin
      locked <= lock_nxt;
      data_out <= lock_nxt && !s1_ctrl ? dec : '0;
      de_out <= lock_nxt && !s1_ctrl;
      ctrl_out <= lock_nxt && s1_ctrl ? dec[1:0] : '0;
      decode_err <= lock_nxt && err;
      skip <= 1'b0;
      if (state == SEARCH) begin
        if (lock_now) begin
          state <= LOCKED;
          run_cnt <= '0;
          dwell_cnt <= '0;
          gap_cnt <= '0;
        end else if (dwell_done) begin
          offset <= offset_inc;
          run_cnt <= '0;
          dwell_cnt <= '0;
          skip <= 1'b1;
        end else begin
          dwell_cnt <= dwell_cnt + 1'b1;
          if (!skip) run_cnt <= s1_ctrl ? run_cnt + 1'b1 : '0;
        end
      end else if (loss_now) begin
        state <= SEARCH;
        offset <= offset_inc;
        gap_cnt <= '0;
        skip <= 1'b1;
      end else
        gap_cnt <= s1_ctrl ? '0 : gap_cnt + 1'b1;
    end
endmodule

// File: doc/tmds_channel_rx.md
Name: tmds_channel_rx

Overview:
- Receive-side counterpart of the TMDS encoder, for one TMDS channel.
- Takes unaligned 10-bit words from a 10:1 deserializer, one per pixel clock, and searches for the character boundary using runs of control tokens.
- Once locked, decodes each character to a data byte, a DE flag and control bits.
- Sits between the deserializer and the video timing recovery logic; the receiver uses three instances.

Parameters:
- LOCK_COUNT, 16, number of consecutive control tokens at the current offset needed to declare lock.
- DWELL_CYCLES, 4400, cycles spent at each candidate offset while searching (two 1080p lines).
- LOSS_TIMEOUT, 4400, cycles without any control token after which lock is dropped.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- raw_in  in  10  deserialized word; bit 0 is the earliest bit received
- data_out  out  8  decoded byte; valid when de_out=1
- de_out  out  1  1 = data character, 0 = control character
- ctrl_out  out  2  decoded control bits {c1,c0}; valid when de_out=0
- locked  out  1  alignment achieved
- offset  out  4  current bit offset, 0..9
- decode_err  out  1  pulses while locked for a word that is not a legal character

Behaviour:
- Reset: clk and rst_n are the only clock and reset. Reset is asynchronous and active-low. On reset all outputs are 0, state=SEARCH, offset=0, all counters 0, raw_prev=0.
- Alignment window: 20-bit w={raw_in, raw_prev}; aligned word a=w[offset+9:offset]. raw_prev<=raw_in every cycle.
- Pipeline:
  - Stage 1 registers a, plus is_ctrl = (a is one of C0..C3).
  - Stage 2 registers the decode outputs.
  - Latency is 2 cycles: the word whose last bit arrives in raw_in at cycle N appears on the outputs at N+2.
- DE inference: TMDS data characters never equal C0..C3, so de = !is_ctrl.
- Decode rules:
  - Data characters follow the DVI 1.0 decode, i.e. the package tmds_decode function with data_active=1.
  - Control characters: C0→00, C1→01, C2→10, C3→11.
  - decode_err=1 when the stage-1 word is not a control token and bits[9:8]=2'b00 with data-only properties violated. Minimum implementation: a data character whose decoded byte re-encodes to a word with a different a[8]. If that check is omitted, decode_err is tied 0 and the bench must accept that.
- While locked=0: data_out=0, de_out=0, ctrl_out=0, decode_err=0.
- State SEARCH:
  - run_cnt increments on each stage-1 is_ctrl and clears on non-ctrl. dwell_cnt increments every cycle.
  - run_cnt reaches LOCK_COUNT → state LOCKED, locked=1 next cycle, offset held.
  - Else dwell_cnt reaches DWELL_CYCLES-1 → offset=(offset==9)?0:offset+1; run_cnt and dwell_cnt clear.
  - Both conditions in the same cycle → lock wins.
  - Stage-1 results are invalid for 1 cycle after an offset change; run_cnt ignores that cycle.
- State LOCKED:
  - gap_cnt clears on any is_ctrl and increments otherwise.
  - gap_cnt reaches LOSS_TIMEOUT → state SEARCH, locked=0, offset advances by 1 (with wrap), counters clear.
- Output timing on lock transitions: outputs begin reflecting decoded words on the first cycle locked=1 and go to 0 on the cycle locked falls.
- Counter widths are $clog2(max+1). Counters saturate and never wrap.

Decomposition:
- pkg_dvi additions:
  - typedef enum tmds_align_state_t {SEARCH, LOCKED}.
  - Function is_control_token(tmds_t).
  - Constant TMDS_BITS=10.
- Reuse the existing pkg_dvi items: C0–C3, tmds_t, tmds_decode, tmds_encode.
- Sub-module tmds_word_aligner: holds raw_prev, performs the 20→10 window select by offset, and registers stage 1 (aligned word plus is_ctrl).

Test Plan (bench params DWELL_CYCLES=32, LOCK_COUNT=8, LOSS_TIMEOUT=64):
1. Continuous C0/C1 alternating stream, characters starting at bit 3 of w → offsets 0,1,2 each dwell 32 cycles; locked=1 with offset=3 within 3*32+8+3 cycles.
2. Locked at offset 3, then send tmds_encode(8'h55, de=1, disparity=0) followed by 8'hA0 → two cycles later de_out=1, data_out=8'h55, then 8'hA0, decode_err=0.
3. Locked, send C3 → two cycles later de_out=0, ctrl_out=2'b11.
4. Locked, send data characters only for 65 cycles → locked falls once gap_cnt reaches 64; offset=4; data_out/de_out forced to 0.
5. No control tokens ever (random data) → offset steps 0..9 then wraps to 0 after 320 cycles; locked stays 0.
6. Assert rst_n=0 mid-lock during active data → all outputs 0 asynchronously; after release, re-lock sequence repeats as in test 1.
